fetch_pc_unit: RTL and testbench

Fetch-stage program-counter generator that sits directly upstream of the branch target buffer. It drives the buffer's lookup PC and consumes its predicted_next_pc / predicted_taken to choose the next fetch PC. It keeps in-flight predictions in a small in-order queue and checks each one against the branch outcome reported by execute. On a mispredict it redirects fetch and flushes, and it generates the buffer's update signals (branch_resolved_*).

---
 rtl/fetch_pc_unit.sv | 125 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator with an in-order prediction queue, mispredict redirect/flush and BTB update.
// Optional build macro BTB_UPDATE_ALL_EN: update the BTB on every resolution, not only on mispredicts.
module fetch_pc_unit #(
  parameter int unsigned     PC_W     = 4,
  parameter int unsigned     QDEPTH   = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  output logic [PC_W-1:0] pc_out,
  input  logic [PC_W-1:0] pred_next_pc,
  input  logic            pred_taken,
  output logic            fetch_valid,
  input  logic            res_valid,
  input  logic            res_taken,
  input  logic [PC_W-1:0] res_target,
  output logic            upd_valid,
  output logic [PC_W-1:0] upd_pc,
  output logic [PC_W-1:0] upd_target,
  output logic            upd_taken,
  output logic            flush,
  output logic            q_full,
  output logic            res_underflow
);

  localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  logic [PC_W-1:0] q_pc    [QDEPTH];
  logic [PC_W-1:0] q_tgt   [QDEPTH];
  logic            q_taken [QDEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;

  logic            q_empty;
  logic            resolve;
  logic            mispredict;
  logic            push;
  logic            pop;
  logic            upd_fire;
  logic [PC_W-1:0] head_seq;
  logic [PC_W-1:0] actual_next;
  logic [PC_W-1:0] predicted_next;

  always_comb begin
    q_empty        = (count == '0);
    q_full         = (count == FULL_CNT);
    resolve        = res_valid && !q_empty;
    head_seq       = q_pc[head] + PC_W'(1);
    actual_next    = res_taken ? res_target : head_seq;
    predicted_next = q_taken[head] ? q_tgt[head] : head_seq;
    mispredict     = resolve && (actual_next != predicted_next);
    fetch_valid    = !stall && !q_full && !mispredict;
    push           = fetch_valid;
    // A mispredict clears the whole queue, so its pop is folded into the clear.
    pop            = resolve && !mispredict;
  end

`ifdef BTB_UPDATE_ALL_EN
  assign upd_fire = resolve;
`else
  assign upd_fire = mispredict;
`endif

  // Queue payload needs no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]    <= pc_out;
      q_taken[tail] <= pred_taken;
      q_tgt[tail]   <= pred_next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out        <= RESET_PC;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      flush         <= 1'b0;
      res_underflow <= 1'b0;
      upd_valid     <= 1'b0;
      upd_pc        <= '0;
      upd_target    <= '0;
      upd_taken     <= 1'b0;
    end else begin
      flush <= mispredict;
      if (res_valid && q_empty) begin
        res_underflow <= 1'b1;
      end

      upd_valid <= upd_fire;
      if (upd_fire) begin
        upd_pc     <= q_pc[head];
        upd_target <= res_target;
        upd_taken  <= res_taken;
      end

      if (mispredict) begin
        pc_out <= actual_next;
        head   <= '0;
        tail   <= '0;
        count  <= '0;
      end else begin
        if (pop) begin
          head <= head + AW'(1);
        end
        if (push) begin
          tail   <= tail + AW'(1);
          pc_out <= pred_taken ? pred_next_pc : pc_out + PC_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: queue-based reference model, directed scenarios, random traffic.
module tb_fetch_pc_unit;

`ifdef BTB_UPDATE_ALL_EN
  localparam bit UPD_ALL = 1'b1;
`else
  localparam bit UPD_ALL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       stall = 1'b0;
  logic [3:0] pc_out;
  logic [3:0] pred_next_pc = '0;
  logic       pred_taken = 1'b0;
  logic       fetch_valid;
  logic       res_valid = 1'b0;
  logic       res_taken = 1'b0;
  logic [3:0] res_target = '0;
  logic       upd_valid;
  logic [3:0] upd_pc;
  logic [3:0] upd_target;
  logic       upd_taken;
  logic       flush;
  logic       q_full;
  logic       res_underflow;

  fetch_pc_unit #(.PC_W(4), .QDEPTH(4), .RESET_PC(4'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_out(pc_out),
    .pred_next_pc(pred_next_pc), .pred_taken(pred_taken), .fetch_valid(fetch_valid),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .flush(flush), .q_full(q_full), .res_underflow(res_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pc;
    logic       taken;
    logic [3:0] tgt;
  } ent_t;

  ent_t       m_q[$];
  logic [3:0] m_pc = '0;
  logic       m_flush = 1'b0, m_under = 1'b0;
  logic       m_upd_v = 1'b0, m_upd_tk = 1'b0;
  logic [3:0] m_upd_pc = '0, m_upd_tg = '0;
  bit         m_init = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model, pass the edge.
  task automatic step(input bit r, input bit st, input bit pt, input logic [3:0] pn,
                      input bit rv, input bit rt, input logic [3:0] rtg);
    bit         resolve, mis, fv;
    logic [3:0] act, prd, seq;
    @(negedge clk);
    reset = r; stall = st; pred_taken = pt; pred_next_pc = pn;
    res_valid = rv; res_taken = rt; res_target = rtg;
    #1;
    resolve = rv && (m_q.size() > 0);
    mis = 1'b0;
    act = '0;
    if (resolve) begin
      seq = m_q[0].pc + 4'd1;
      act = rt ? rtg : seq;
      prd = m_q[0].taken ? m_q[0].tgt : seq;
      mis = (act != prd);
    end
    fv = !st && (m_q.size() < 4) && !mis;
    if (m_init) begin
      chk("pc_out", 32'(pc_out), 32'(m_pc));
      chk("fetch_valid", 32'(fetch_valid), 32'(fv));
      chk("flush", 32'(flush), 32'(m_flush));
      chk("upd_valid", 32'(upd_valid), 32'(m_upd_v));
      chk("upd_pc", 32'(upd_pc), 32'(m_upd_pc));
      chk("upd_target", 32'(upd_target), 32'(m_upd_tg));
      chk("upd_taken", 32'(upd_taken), 32'(m_upd_tk));
      chk("q_full", 32'(q_full), 32'(m_q.size() == 4));
      chk("res_underflow", 32'(res_underflow), 32'(m_under));
    end
    if (r) begin
      m_pc = 4'h0; m_q.delete(); m_flush = 0; m_under = 0;
      m_upd_v = 0; m_upd_pc = '0; m_upd_tg = '0; m_upd_tk = 0;
      m_init = 1'b1;
    end else begin
      m_flush = mis;
      if (rv && m_q.size() == 0) m_under = 1'b1;
      if (UPD_ALL ? resolve : mis) begin
        m_upd_v = 1'b1; m_upd_pc = m_q[0].pc; m_upd_tg = rtg; m_upd_tk = rt;
      end else begin
        m_upd_v = 1'b0;
      end
      if (mis) begin
        m_pc = act;
        m_q.delete();
      end else begin
        if (resolve) void'(m_q.pop_front());
        if (fv) begin
          m_q.push_back('{pc: m_pc, taken: pt, tgt: pn});
          m_pc = pt ? pn : m_pc + 4'd1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Sequential fetch with wrap: one entry stays in flight, resolved correctly every cycle.
    step(1, 0, 0, 4'h0, 0, 0, 4'h0);
    chk("reset_pc", 32'(pc_out), 32'h0);
    step(0, 0, 0, 4'h0, 0, 0, 4'h0);
    chk("seq_pc1", 32'(pc_out), 32'h1);
    for (int i = 2; i <= 17; i++) begin
      step(0, 0, 0, 4'h0, 1, 0, 4'h0);
      chk("seq_wrap_pc", 32'(pc_out), 32'(i % 16));
    end

    // Fill the queue with no resolutions, then pc_out holds.
    step(1, 0, 0, 4'h0, 0, 0, 4'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'h0, 0, 0, 4'h0);
    chk("full_flag", 32'(q_full), 32'h1);
    chk("full_pc", 32'(pc_out), 32'h4);
    step(0, 0, 0, 4'h0, 0, 0, 4'h0);
    chk("full_hold_pc", 32'(pc_out), 32'h4);

    // Correct taken prediction, then a mispredicted not-taken at pc 5 resolved taken to C.
    step(1, 0, 0, 4'h0, 0, 0, 4'h0);
    step(0, 0, 1, 4'h5, 0, 0, 4'h0);
    chk("taken_pred_pc", 32'(pc_out), 32'h5);
    step(0, 0, 0, 4'h0, 0, 0, 4'h0);
    step(0, 1, 0, 4'h0, 1, 1, 4'h5);
    chk("correct_no_flush", 32'(flush), 32'h0);
    chk("correct_upd_valid", 32'(upd_valid), 32'(UPD_ALL));
    step(0, 1, 0, 4'h0, 1, 1, 4'hC);
    chk("mis_flush", 32'(flush), 32'h1);
    chk("mis_pc", 32'(pc_out), 32'hC);
    chk("mis_upd_valid", 32'(upd_valid), 32'h1);
    chk("mis_upd_pc", 32'(upd_pc), 32'h5);
    chk("mis_upd_target", 32'(upd_target), 32'hC);
    chk("mis_upd_taken", 32'(upd_taken), 32'h1);
    step(0, 0, 0, 4'h0, 0, 0, 4'h0);
    chk("flush_one_cycle", 32'(flush), 32'h0);
    chk("after_mis_pc", 32'(pc_out), 32'hD);

    // Mispredict while stalled and full: redirect still wins, fetch resumes after stall drops.
    step(1, 0, 0, 4'h0, 0, 0, 4'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'h0, 0, 0, 4'h0);
    step(0, 1, 0, 4'h0, 1, 1, 4'hA);
    chk("stall_mis_flush", 32'(flush), 32'h1);
    chk("stall_mis_pc", 32'(pc_out), 32'hA);
    chk("stall_mis_qfull", 32'(q_full), 32'h0);
    step(0, 0, 0, 4'h0, 0, 0, 4'h0);
    chk("resume_pc", 32'(pc_out), 32'hB);

    // Resolution with an empty queue is sticky until reset.
    step(1, 0, 0, 4'h0, 0, 0, 4'h0);
    step(0, 1, 0, 4'h0, 1, 1, 4'h7);
    chk("underflow_pc", 32'(pc_out), 32'h0);
    chk("underflow_set", 32'(res_underflow), 32'h1);
    step(0, 1, 0, 4'h0, 0, 0, 4'h0);
    chk("underflow_sticky", 32'(res_underflow), 32'h1);
    step(1, 0, 0, 4'h0, 0, 0, 4'h0);
    chk("underflow_cleared", 32'(res_underflow), 32'h0);

    // Reset beats a same-cycle mispredict with three entries in flight.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4'h0, 0, 0, 4'h0);
    step(1, 0, 0, 4'h0, 1, 1, 4'hA);
    chk("rst_mid_pc", 32'(pc_out), 32'h0);
    chk("rst_mid_upd", 32'(upd_valid), 32'h0);
    chk("rst_mid_flush", 32'(flush), 32'h0);
    chk("rst_mid_qfull", 32'(q_full), 32'h0);

    // Random traffic; resolutions often agree with the queued prediction.
    for (int n = 0; n < 3000; n++) begin
      bit         r, st, pt, rv, rt;
      logic [3:0] pn, rtg;
      r   = ($urandom_range(0, 149) == 0);
      st  = ($urandom_range(0, 3) == 0);
      pt  = $urandom_range(0, 1);
      pn  = 4'($urandom_range(0, 15));
      rv  = ($urandom_range(0, 9) < 4);
      rt  = $urandom_range(0, 1);
      rtg = 4'($urandom_range(0, 15));
      if (m_q.size() > 0 && $urandom_range(0, 9) < 6) begin
        rt  = m_q[0].taken;
        rtg = m_q[0].taken ? m_q[0].tgt : rtg;
      end
      step(r, st, pt, pn, rv, rt, rtg);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
